// File: rtl/pcpu_prog_loader.sv
// Instruction-RAM loader for the pipelined CPU: streams a program in, pads with HALT, then releases the CPU.
// Optional trailing-checksum stage enabled by defining LOADER_CHECKSUM_EN.
module pcpu_prog_loader #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 256,
    parameter logic [DATA_W-1:0] FILL_WORD = 16'h1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] instruction,
    output logic              cpu_reset,
    output logic              cpu_enable,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_LEN   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    // states: IDLE cpu held, waiting | LOAD take stream | FILL pad HALT | CHK verify sum | START release pulse | RUN serve fetch
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_START,
        S_RUN
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_DATA_DONE = S_CHK;
`else
    localparam state_t S_DATA_DONE = S_START;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic              err_q, err_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              len_legal;
    logic              req_taken;
    logic              stream_phase;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    assign len_legal = (load_len != '0) && (load_len <= MAX_LEN);
    assign req_taken = load_req &&
                       ((state_q == S_IDLE) || (state_q == S_START) || (state_q == S_RUN));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wptr_d    = wptr_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_wdata = in_data;
`ifdef LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                if (in_valid) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + ONE;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + in_data;
`endif
                    if (wptr_q == len_q - ONE) begin
                        state_d = (len_q == MAX_LEN) ? S_DATA_DONE : S_FILL;
                    end
                end
            end
            S_FILL: begin
                mem_we    = 1'b1;
                mem_wdata = FILL_WORD;
                wptr_d    = wptr_q + ONE;
                if (wptr_q == LAST_ADDR) begin
                    state_d = S_DATA_DONE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (in_valid) begin
                    if (in_data == sum_q) begin
                        state_d = S_START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_START: state_d = S_RUN;
            S_RUN: ;
            default: state_d = S_IDLE;
        endcase

        // A request from IDLE/START/RUN (re)starts a load; an illegal length parks in IDLE with err.
        if (req_taken) begin
            if (len_legal) begin
                state_d = S_LOAD;
                len_d   = load_len;
                wptr_d  = '0;
                err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                sum_d   = '0;
`endif
            end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            wptr_q  <= '0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wptr_q  <= wptr_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // RAM is deliberately not reset so a reset mid-load keeps the partial image.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= mem_wdata;
        end
    end

    assign instruction = mem_q[i_addr];

`ifdef LOADER_CHECKSUM_EN
    assign stream_phase = (state_q == S_LOAD) || (state_q == S_CHK);
`else
    assign stream_phase = (state_q == S_LOAD);
`endif

    assign in_ready   = stream_phase;
    assign busy       = stream_phase || (state_q == S_FILL);
    assign cpu_enable = (state_q == S_START) || (state_q == S_RUN);
    assign cpu_reset  = !cpu_enable;
    assign cpu_start  = (state_q == S_START);
    assign done       = (state_q == S_RUN);
    assign err        = err_q;

endmodule

// File: tb/tb_pcpu_prog_loader.sv
// Bench for pcpu_prog_loader: per-cycle compare against a phase/queue model plus literal spot checks.
`timescale 1ns/1ps
module tb_pcpu_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic [8:0]  load_len = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [7:0]  i_addr = '0;
    logic        in_ready, cpu_reset, cpu_enable, cpu_start, busy, done, err;
    logic [15:0] instruction;

    always #5 clk = ~clk;

    pcpu_prog_loader dut (
        .clk(clk), .reset(reset), .load_req(load_req), .load_len(load_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .i_addr(i_addr), .instruction(instruction),
        .cpu_reset(cpu_reset), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
        .busy(busy), .done(done), .err(err)
    );

    localparam int P_IDLE = 0, P_LOAD = 1, P_FILL = 2, P_CHK = 3, P_START = 4, P_RUN = 5;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    int          m_ph = P_IDLE;
    bit          m_err = 1'b0;
    int          m_len = 0;
    int          m_fill_left = 0;
    logic [15:0] m_prog[$];
    logic [15:0] m_mem[256];

    int checks = 0, failures = 0;
    int cyc = 0, n_start = 0, start_cyc = -1, ready_seen = 0;
    int acc_q[$];
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] prog_sum();
        logic [15:0] s = '0;
        foreach (m_prog[i]) s = s + m_prog[i];
        return s;
    endfunction

    task automatic m_enter_start();
        for (int i = 0; i < 256; i++) m_mem[i] = (i < m_len) ? m_prog[i] : 16'h1000;
        m_ph = P_START;
    endtask

    task automatic m_data_done();
        if (CHK_EN) m_ph = P_CHK;
        else m_enter_start();
    endtask

    task automatic model_step();
        int ph0;
        if (reset) begin
            m_ph  = P_IDLE;
            m_err = 1'b0;
            return;
        end
        ph0 = m_ph;
        case (m_ph)
            P_LOAD: if (in_valid) begin
                m_prog.push_back(in_data);
                if (m_prog.size() == m_len) begin
                    if (m_len < 256) begin
                        m_fill_left = 256 - m_len;
                        m_ph = P_FILL;
                    end else m_data_done();
                end
            end
            P_FILL: begin
                m_fill_left--;
                if (m_fill_left == 0) m_data_done();
            end
            P_CHK: if (in_valid) begin
                if (in_data == prog_sum()) m_enter_start();
                else begin m_err = 1'b1; m_ph = P_IDLE; end
            end
            P_START: m_ph = P_RUN;
            default: ;
        endcase
        if (load_req && (ph0 == P_IDLE || ph0 == P_START || ph0 == P_RUN)) begin
            if (load_len >= 1 && load_len <= 256) begin
                m_len = int'(load_len);
                m_prog.delete();
                m_err = 1'b0;
                m_ph  = P_LOAD;
            end else begin
                m_err = 1'b1;
                m_ph  = P_IDLE;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Single compare process: every falling edge, all outputs against the model.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (cmp_en) begin
            check("in_ready",   in_ready,   m_ph == P_LOAD || m_ph == P_CHK);
            check("busy",       busy,       m_ph == P_LOAD || m_ph == P_FILL || m_ph == P_CHK);
            check("cpu_enable", cpu_enable, m_ph == P_START || m_ph == P_RUN);
            check("cpu_reset",  cpu_reset,  !(m_ph == P_START || m_ph == P_RUN));
            check("cpu_start",  cpu_start,  m_ph == P_START);
            check("done",       done,       m_ph == P_RUN);
            check("err",        err,        m_err);
            if (m_ph == P_RUN) check("instruction", instruction, m_mem[i_addr]);
        end
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (cpu_start) begin n_start++; start_cyc = cyc; end
        if (in_ready) ready_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int len);
        load_req = 1'b1;
        load_len = 9'(len);
        tick();
        load_req = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input bit gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            failures++;
            $display("FAIL send_timeout actual=no_ready expected=ready word=%0h", w);
        end
        tick();
        in_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic send_sum(input logic [15:0] w);
`ifdef LOADER_CHECKSUM_EN
        send(w, 1'b0);
`else
        if (w === 16'hxxxx) tick();
`endif
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin tick(); n++; end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL wait_done actual=%0b expected=1 after %0d cycles", done, budget);
        end
    endtask

    task automatic sweep();
        for (int a = 0; a < 256; a++) begin
            i_addr = 8'(a);
            tick();
        end
    endtask

    task automatic peek(input string name, input logic [7:0] a, input logic [15:0] exp);
        i_addr = a;
        #1;
        check(name, instruction, exp);
    endtask

    initial begin
        logic [15:0] s;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_cpu_enable", cpu_enable, 1'b0);
        check("rst_cpu_start", cpu_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;
        tick();

        // T1: reset mid-stream takes effect without a clock edge
        req(5);
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h3333;
        #2 reset = 1'b1;
        #1;
        check("t1_in_ready", in_ready, 1'b0);
        check("t1_cpu_reset", cpu_reset, 1'b1);
        check("t1_busy", busy, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();

        // T3: illegal lengths
        ready_seen = 0;
        req(0);
        check("t3_err_len0", err, 1'b1);
        req(300);
        check("t3_err_len300", err, 1'b1);
        tick();
        check("t3_busy", busy, 1'b0);
        check("t3_ready_seen", 32'(ready_seen), 32'd0);

        // T2: 3 words with gaps; load_req inside LOAD is ignored
        acc_q.delete();
        n_start = 0;
        req(3);
        check("t2_err_cleared", err, 1'b0);
        send(16'h3101, 1'b1);
        req(0);
        check("t2_req_ignored_err", err, 1'b0);
        send(16'h3202, 1'b1);
        send(16'h0000, 1'b1);
        send_sum(16'h6303);
        wait_done(600);
        check("t2_start_count", 32'(n_start), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        check("t2_fill_gap", 32'(start_cyc - acc_q[2] - 1), 32'd254);
`else
        check("t2_fill_gap", 32'(start_cyc - acc_q[2] - 1), 32'd253);
`endif
        peek("t2_mem0", 8'd0, 16'h3101);
        peek("t2_mem1", 8'd1, 16'h3202);
        peek("t2_mem2", 8'd2, 16'h0000);
        peek("t2_mem3", 8'd3, 16'h1000);
        peek("t2_mem255", 8'd255, 16'h1000);
        sweep();

        // T5: abort from RUN and reload 2 words
        n_start = 0;
        req(2);
        check("t5_cpu_enable", cpu_enable, 1'b0);
        check("t5_cpu_reset", cpu_reset, 1'b1);
        check("t5_in_ready", in_ready, 1'b1);
        check("t5_done", done, 1'b0);
        send(16'hBEEF, 1'b0);
        send(16'h0042, 1'b0);
        send_sum(16'hBF31);
        wait_done(600);
        check("t5_start_count", 32'(n_start), 32'd1);
        peek("t5_mem0", 8'd0, 16'hBEEF);
        peek("t5_mem1", 8'd1, 16'h0042);
        peek("t5_mem2", 8'd2, 16'h1000);
        sweep();

        // illegal length while running drops to IDLE with err
        req(257);
        check("abort_bad_err", err, 1'b1);
        check("abort_bad_done", done, 1'b0);
        check("abort_bad_cpu_reset", cpu_reset, 1'b1);

        // T4: full 256-word program, no FILL
        acc_q.delete();
        n_start = 0;
        s = '0;
        req(256);
        check("t4_err_cleared", err, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send(16'hA000 | 16'(i), 1'b0);
            s = s + (16'hA000 | 16'(i));
        end
        send_sum(s);
        wait_done(50);
        check("t4_start_count", 32'(n_start), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        check("t4_gap", 32'(start_cyc - acc_q[255] - 1), 32'd1);
`else
        check("t4_gap", 32'(start_cyc - acc_q[255] - 1), 32'd0);
`endif
        peek("t4_mem255", 8'd255, 16'hA0FF);
        peek("t4_mem0", 8'd0, 16'hA000);
        sweep();

`ifdef LOADER_CHECKSUM_EN
        // T6: good then bad checksum
        n_start = 0;
        req(2);
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        wait_done(600);
        check("t6_good_start", 32'(n_start), 32'd1);
        req(2);
        n_start = 0;
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0004, 1'b0);
        repeat (3) tick();
        check("t6_bad_err", err, 1'b1);
        check("t6_bad_start", 32'(n_start), 32'd0);
        check("t6_bad_cpu_reset", cpu_reset, 1'b1);
        check("t6_bad_done", done, 1'b0);
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
